// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared RX state encoding and baud divisor helper
package uart_loader_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: rx synchroniser, 8N1 receive FSM and bit timer
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CPB = 16
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] byte_q,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(CPB);
  localparam logic [TW-1:0] FULL = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF = TW'(CPB / 2 - 1);
  logic [1:0] sync;
  logic rxs;
  rx_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic valid_n, err_n;
  assign rxs = sync[1];
  assign byte_q = shift;
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    bit_idx_n = bit_idx;
    shift_n = shift;
    valid_n = 1'b0;
    err_n = 1'b0;
    case (state)
      RX_IDLE: begin
        timer_n = '0;
        bit_idx_n = '0;
        state_n = rxs ? RX_IDLE : RX_START;
      end
      RX_START: if (timer == HALF) begin
        timer_n = '0;
        state_n = rxs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (timer == FULL) begin
        timer_n = '0;
        shift_n = {rxs, shift[7:1]};
        bit_idx_n = bit_idx + 1'b1;
        state_n = (bit_idx == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (timer == FULL) begin
        timer_n = '0;
        state_n = RX_IDLE;
        valid_n = rxs;
        err_n = ~rxs;
      end
      default: state_n = RX_IDLE;
    endcase
    if (!enable) begin
      state_n = RX_IDLE;
      timer_n = '0;
      valid_n = 1'b0;
      err_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (Rst) begin
      sync <= 2'b11;
      state <= RX_IDLE;
      timer <= '0;
      bit_idx <= '0;
      shift <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      state <= state_n;
      timer <= timer_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
      byte_valid <= valid_n;
      frame_err <= err_n;
    end
  end
endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: UART boot loader packing bytes into little-endian imem words
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              prog,
  input  logic              rx,
  output logic [31:0]       imem_din,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_wea,
  output logic              prog_ena,
  output logic [ADDR_W-2:0] word_cnt,
  output logic              frame_err
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  logic [7:0] byte_q;
  logic byte_valid;
  logic [1:0] byte_idx;
  logic [23:0] word_lo;
  logic [ADDR_W-1:0] word_addr;
  logic rise;
  assign rise = prog & ~prog_ena;
  uart_rx_byte #(.CPB(CPB)) u_rx (
    .clk(clk),
    .Rst(Rst),
    .enable(prog_ena),
    .rx(rx),
    .byte_q(byte_q),
    .byte_valid(byte_valid),
    .frame_err(frame_err)
  );
  // the three earlier bytes shift down so the fourth lands directly on top
  always_ff @(posedge clk) begin
    if (Rst) begin
      prog_ena <= 1'b0;
      imem_wea <= 1'b0;
      imem_din <= '0;
      imem_addr <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      word_lo <= '0;
      word_addr <= '0;
    end else begin
      prog_ena <= prog;
      imem_wea <= 1'b0;
      if (rise) begin
        byte_idx <= '0;
        word_addr <= '0;
        word_cnt <= '0;
      end else if (!prog) begin
        byte_idx <= '0;
      end else if (byte_valid) begin
        byte_idx <= byte_idx + 1'b1;
        word_lo <= {byte_q, word_lo[23:8]};
        if (byte_idx == 2'd3) begin
          imem_wea <= 1'b1;
          imem_din <= {byte_q, word_lo};
          imem_addr <= word_addr;
          word_addr <= word_addr + ADDR_W'(4);
          if (~&word_cnt) word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed checks of UART byte reception, packing and imem writes
module tb_uart_imem_loader;
  logic clk = 1'b0;
  logic Rst = 1'b1;
  logic prog = 1'b0;
  logic rx = 1'b1;
  logic [31:0] imem_din;
  logic [3:0] imem_addr;
  logic imem_wea;
  logic prog_ena;
  logic [2:0] word_cnt;
  logic frame_err;
  int passed = 0;
  int total = 0;
  logic [31:0] wr_din[$];
  logic [3:0] wr_addr[$];
  int ferr_n = 0;
  int base;
  int fbase;
  uart_imem_loader #(.CLK_HZ(1_600_000), .BAUD(100_000), .ADDR_W(4)) dut (
    .clk(clk),
    .Rst(Rst),
    .prog(prog),
    .rx(rx),
    .imem_din(imem_din),
    .imem_addr(imem_addr),
    .imem_wea(imem_wea),
    .prog_ena(prog_ena),
    .word_cnt(word_cnt),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (imem_wea) begin
      wr_din.push_back(imem_din);
      wr_addr.push_back(imem_addr);
    end
    if (frame_err) ferr_n++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1, input int stop_len = 16);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  task automatic prog_cycle();
    prog = 1'b0;
    repeat (4) @(negedge clk);
    prog = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wea", imem_wea, 0);
    chk("rst_din", imem_din, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_prog_ena", prog_ena, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_ferr", frame_err, 0);
    Rst = 1'b0;
    // single word
    prog = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_prog_ena", prog_ena, 1);
    base = wr_din.size();
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    repeat (20) @(negedge clk);
    chk("t1_nwr", wr_din.size() - base, 1);
    chk("t1_din", wr_din[base], 32'h00A0_0513);
    chk("t1_addr", wr_addr[base], 0);
    chk("t1_hold_din", imem_din, 32'h00A0_0513);
    chk("t1_cnt", word_cnt, 1);
    // three words back-to-back
    prog_cycle();
    base = wr_din.size();
    send_word(32'hDEAD_BEEF); send_word(32'h0123_4567); send_word(32'hCAFE_F00D);
    repeat (20) @(negedge clk);
    chk("t2_nwr", wr_din.size() - base, 3);
    chk("t2_din0", wr_din[base], 32'hDEAD_BEEF);
    chk("t2_addr0", wr_addr[base], 0);
    chk("t2_din1", wr_din[base+1], 32'h0123_4567);
    chk("t2_addr1", wr_addr[base+1], 4);
    chk("t2_din2", wr_din[base+2], 32'hCAFE_F00D);
    chk("t2_addr2", wr_addr[base+2], 8);
    chk("t2_cnt", word_cnt, 3);
    // bad stop bit; low stop is kept just past its sample so the line is idle at restart
    prog_cycle();
    base = wr_din.size();
    fbase = ferr_n;
    send_byte(8'h55, 1'b0, 12);
    repeat (48) @(negedge clk);
    chk("t3_ferr", ferr_n - fbase, 1);
    chk("t3_nwr_bad", wr_din.size() - base, 0);
    send_word(32'h7654_3210);
    repeat (20) @(negedge clk);
    chk("t3_nwr", wr_din.size() - base, 1);
    chk("t3_din", wr_din[base], 32'h7654_3210);
    chk("t3_addr", wr_addr[base], 0);
    // partial word discarded on prog drop
    prog_cycle();
    base = wr_din.size();
    send_byte(8'hAA); send_byte(8'hBB);
    prog_cycle();
    send_word(32'h4433_2211);
    repeat (20) @(negedge clk);
    chk("t4_nwr", wr_din.size() - base, 1);
    chk("t4_din", wr_din[base], 32'h4433_2211);
    chk("t4_addr", wr_addr[base], 0);
    // short glitch on rx
    prog_cycle();
    base = wr_din.size();
    fbase = ferr_n;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_nwr", wr_din.size() - base, 0);
    chk("t5_ferr", ferr_n - fbase, 0);
    send_word(32'h0BAD_CAFE);
    repeat (20) @(negedge clk);
    chk("t5_din", wr_din[base], 32'h0BAD_CAFE);
    chk("t5_addr", wr_addr[base], 0);
    // reset in the middle of byte 3
    prog_cycle();
    send_byte(8'h01); send_byte(8'h02);
    rx = 1'b0;
    repeat (60) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    rx = 1'b1;
    chk("t6_wea", imem_wea, 0);
    chk("t6_din", imem_din, 0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_prog_ena", prog_ena, 0);
    chk("t6_cnt", word_cnt, 0);
    chk("t6_ferr", frame_err, 0);
    Rst = 1'b0;
    repeat (40) @(negedge clk);
    base = wr_din.size();
    send_word(32'h1357_9BDF);
    repeat (20) @(negedge clk);
    chk("t6_nwr", wr_din.size() - base, 1);
    chk("t6_din_w", wr_din[base], 32'h1357_9BDF);
    chk("t6_addr_w", wr_addr[base], 0);
    chk("t6_cnt_w", word_cnt, 1);
    // address wrap past 12 and counter saturation at 7
    for (int i = 1; i < 8; i++) send_word(32'hA5A5_0000 | i);
    repeat (20) @(negedge clk);
    chk("wrap_nwr", wr_din.size() - base, 8);
    chk("wrap_addr12", wr_addr[base+3], 12);
    chk("wrap_addr0", wr_addr[base+4], 0);
    chk("wrap_din", wr_din[base+4], 32'hA5A5_0004);
    chk("wrap_addr4", wr_addr[base+5], 4);
    chk("sat_cnt", word_cnt, 7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
